// File: rtl/sram_ctrl.sv
// Single-access initiator for a 16-bit asynchronous SRAM. Every pin and the DQ
// drive enable is registered, so request inputs never reach the pads combinationally.
`timescale 1ns/1ps

module sram_ctrl #(
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              req,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        byte_en,
   output logic              ready,
   output logic              done,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   inout  wire  [DATA_W-1:0] SRAM_DQ
);

   localparam int          HALF_W    = DATA_W / 2;
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      DONE
   } state_t;

   state_t              state;
   logic [3:0]          wait_cnt;
   logic                lat_rw;
   logic [1:0]          lat_be;
   logic                dq_oe;
   logic [DATA_W-1:0]   dq_out;
   logic [DATA_W-1:0]   lane_mask;

   // Disabled byte lanes read back as zero rather than whatever floats on the bus.
   assign lane_mask = {{HALF_W{lat_be[1]}}, {HALF_W{lat_be[0]}}};
   assign SRAM_DQ   = dq_oe ? dq_out : {DATA_W{1'bz}};

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         lat_rw    <= 1'b0;
         lat_be    <= 2'b00;
         ready     <= 1'b1;
         done      <= 1'b0;
         rvalid    <= 1'b0;
         rdata     <= '0;
         SRAM_ADDR <= '0;
         SRAM_CE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_WE_N <= 1'b1;
         SRAM_UB_N <= 1'b1;
         SRAM_LB_N <= 1'b1;
         dq_oe     <= 1'b0;
         dq_out    <= '0;
      end else begin
         done   <= 1'b0;
         rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  state     <= SETUP;
                  ready     <= 1'b0;
                  lat_rw    <= rw;
                  lat_be    <= byte_en;
                  SRAM_ADDR <= addr;
                  SRAM_CE_N <= 1'b0;
                  SRAM_UB_N <= ~byte_en[1];
                  SRAM_LB_N <= ~byte_en[0];
                  SRAM_OE_N <= rw;
                  dq_oe     <= rw;
                  dq_out    <= wdata;
               end
            end
            SETUP: begin
               state    <= ACCESS;
               wait_cnt <= WAIT_LOAD;
               if (lat_rw) begin
                  SRAM_WE_N <= 1'b0;
               end
            end
            ACCESS: begin
               if (wait_cnt == 4'd0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  // Writes keep CE and data driven one more cycle for hold after WE rises.
                  if (lat_rw) begin
                     SRAM_WE_N <= 1'b1;
                  end else begin
                     rvalid    <= 1'b1;
                     rdata     <= SRAM_DQ & lane_mask;
                     SRAM_OE_N <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            DONE: begin
               state     <= IDLE;
               ready     <= 1'b1;
               SRAM_CE_N <= 1'b1;
               SRAM_OE_N <= 1'b1;
               SRAM_WE_N <= 1'b1;
               SRAM_UB_N <= 1'b1;
               SRAM_LB_N <= 1'b1;
               dq_oe     <= 1'b0;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a cycle-level SRAM model behind three controller instances
// (WAIT_CYCLES 1, 0 and 3) with a queue of expected read data.
`timescale 1ns/1ps

module tb_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, req0, req3;
   logic        rw;
   logic [19:0] addr;
   logic [15:0] wdata;
   logic [1:0]  be;

   logic        ready, done, rvalid, ce_n, oe_n, we_n, ub_n, lb_n;
   logic [15:0] rdata;
   logic [19:0] s_addr;
   wire  [15:0] dq;

   logic        ready0, done0, rvalid0, ce0, oe0, we0, ub0, lb0;
   logic [15:0] rdata0;
   logic [19:0] s_addr0;
   wire  [15:0] dq0;

   logic        ready3, done3, rvalid3, ce3, oe3, we3, ub3, lb3;
   logic [15:0] rdata3;
   logic [19:0] s_addr3;
   wire  [15:0] dq3;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   sram_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1)) dut (
      .Clk(clk), .Reset_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
      .byte_en(be), .ready(ready), .done(done), .rvalid(rvalid), .rdata(rdata),
      .SRAM_ADDR(s_addr), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_DQ(dq));

   sram_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(0)) dut_w0 (
      .Clk(clk), .Reset_n(rst_n), .req(req0), .rw(rw), .addr(addr), .wdata(wdata),
      .byte_en(be), .ready(ready0), .done(done0), .rvalid(rvalid0), .rdata(rdata0),
      .SRAM_ADDR(s_addr0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0), .SRAM_WE_N(we0),
      .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_DQ(dq0));

   sram_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(3)) dut_w3 (
      .Clk(clk), .Reset_n(rst_n), .req(req3), .rw(rw), .addr(addr), .wdata(wdata),
      .byte_en(be), .ready(ready3), .done(done3), .rvalid(rvalid3), .rdata(rdata3),
      .SRAM_ADDR(s_addr3), .SRAM_CE_N(ce3), .SRAM_OE_N(oe3), .SRAM_WE_N(we3),
      .SRAM_UB_N(ub3), .SRAM_LB_N(lb3), .SRAM_DQ(dq3));

   // SRAM model: data becomes valid in the tAA-th cycle of CE/OE low, garbage before.
   logic [15:0] mem [0:255];
   int oe_cnt = 0, oe_cnt0 = 0, oe_cnt3 = 0;

   always @(posedge clk) begin
      oe_cnt  <= (!ce_n && !oe_n) ? oe_cnt + 1 : 0;
      oe_cnt0 <= (!ce0 && !oe0) ? oe_cnt0 + 1 : 0;
      oe_cnt3 <= (!ce3 && !oe3) ? oe_cnt3 + 1 : 0;
      if (!ce_n && !we_n) begin
         if (!ub_n) mem[s_addr[7:0]][15:8] <= dq[15:8];
         if (!lb_n) mem[s_addr[7:0]][7:0]  <= dq[7:0];
      end
   end

   assign dq  = (!ce_n && !oe_n && we_n) ? ((oe_cnt >= 2) ? mem[s_addr[7:0]] : ~mem[s_addr[7:0]]) : 16'bz;
   assign dq0 = (!ce0 && !oe0 && we0) ? ((oe_cnt0 >= 1) ? (s_addr0[15:0] ^ 16'h5A5A) : ~(s_addr0[15:0] ^ 16'h5A5A)) : 16'bz;
   assign dq3 = (!ce3 && !oe3 && we3) ? ((oe_cnt3 >= 4) ? (s_addr3[15:0] ^ 16'h5A5A) : ~(s_addr3[15:0] ^ 16'h5A5A)) : 16'bz;

   logic [15:0] exp_q [$];
   int          lat;
   logic        rdy0;
   logic        tr_ce [0:24], tr_oe [0:24], tr_we [0:24], tr_ub [0:24], tr_lb [0:24];
   logic        tr_rdy [0:24], tr_rv [0:24];
   logic [15:0] tr_dq [0:24];
   logic [19:0] tr_addr [0:24];

   // Issues one request on the main instance and records pins per cycle until done.
   task automatic send(input logic wr, input logic [19:0] a, input logic [15:0] d,
                       input logic [1:0] b, input bit noise);
      @(negedge clk);
      rdy0 = ready;
      req = 1'b1; rw = wr; addr = a; wdata = d; be = b;
      @(posedge clk);
      #1;
      if (!noise) req = 1'b0;
      rw = 1'($urandom); addr = 20'($urandom); wdata = 16'($urandom); be = 2'($urandom);
      lat = 0;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         tr_ce[k] = ce_n; tr_oe[k] = oe_n; tr_we[k] = we_n; tr_ub[k] = ub_n; tr_lb[k] = lb_n;
         tr_rdy[k] = ready; tr_rv[k] = rvalid; tr_dq[k] = dq; tr_addr[k] = s_addr;
         if (done) begin
            lat = k;
            req = 1'b0;
            break;
         end
         if (noise) begin
            req = 1'($urandom); addr = 20'($urandom); wdata = 16'($urandom);
         end
      end
      req = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = 0; req0 = 0; req3 = 0; rw = 0; addr = '0; wdata = '0; be = 2'b00;
      #12;
      total_cnt++;
      if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111)
         $display("[TB] FAIL reset_strobes: got %b want 11111", {ce_n, oe_n, we_n, ub_n, lb_n});
      else pass_cnt++;
      total_cnt++;
      if ({s_addr, rdata, done, rvalid} !== '0)
         $display("[TB] FAIL reset_regs: addr %h rdata %h done %b rvalid %b want all 0", s_addr, rdata, done, rvalid);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({ready, ready0, ready3} !== 3'b111)
         $display("[TB] FAIL reset_ready: got %b want 111", {ready, ready0, ready3});
      else pass_cnt++;
   endtask

   task automatic test_write_read();
      int we_low, oe_low, ce_high;
      logic dq_ok;
      send(1'b1, 20'h00012, 16'hBEEF, 2'b11, 1'b0);
      total_cnt++;
      if (lat !== 4 || rdy0 !== 1'b1)
         $display("[TB] FAIL wr_latency: got done at %0d (ready %b) want 4", lat, rdy0);
      else pass_cnt++;
      we_low = 0; oe_low = 0; ce_high = 0; dq_ok = 1'b1;
      for (int k = 1; k <= lat; k++) begin
         if (!tr_we[k]) begin
            we_low++;
            if (tr_dq[k] !== 16'hBEEF) dq_ok = 1'b0;
         end
         if (!tr_oe[k]) oe_low++;
         if (tr_ce[k]) ce_high++;
      end
      total_cnt++;
      if (we_low !== 2 || oe_low !== 0 || ce_high !== 0 || !dq_ok)
         $display("[TB] FAIL wr_strobes: we_low %0d oe_low %0d ce_high %0d dq_ok %b want 2 0 0 1", we_low, oe_low, ce_high, dq_ok);
      else pass_cnt++;
      total_cnt++;
      if (lat > 0 && (tr_we[lat] !== 1'b1 || tr_dq[lat] !== 16'hBEEF))
         $display("[TB] FAIL wr_hold: we %b dq %h want 1 beef", tr_we[lat], tr_dq[lat]);
      else pass_cnt++;
      total_cnt++;
      if (mem[8'h12] !== 16'hBEEF)
         $display("[TB] FAIL wr_mem: got %h want beef", mem[8'h12]);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({done, ready, ce_n} !== 3'b011)
         $display("[TB] FAIL wr_after: done/ready/ce %b want 011", {done, ready, ce_n});
      else pass_cnt++;

      exp_q.push_back(16'hBEEF);
      send(1'b0, 20'h00012, 16'h0000, 2'b11, 1'b0);
      oe_low = 0; we_low = 0;
      for (int k = 1; k <= lat; k++) begin
         if (!tr_oe[k]) oe_low++;
         if (!tr_we[k]) we_low++;
      end
      total_cnt++;
      if (lat !== 4 || (lat > 0 && tr_rv[lat] !== 1'b1))
         $display("[TB] FAIL rd_latency: done at %0d rvalid %b want 4 1", lat, (lat > 0) ? tr_rv[lat] : 1'b0);
      else pass_cnt++;
      total_cnt++;
      if (oe_low !== 3 || we_low !== 0)
         $display("[TB] FAIL rd_strobes: oe_low %0d we_low %0d want 3 0", oe_low, we_low);
      else pass_cnt++;
      if (exp_q.size() > 0) begin
         total_cnt++;
         if (rdata !== exp_q[0])
            $display("[TB] FAIL rd_data: got %h want %h", rdata, exp_q[0]);
         else pass_cnt++;
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_byte_lanes();
      logic ub_ok, lb_ok;
      send(1'b1, 20'h00040, 16'hFFFF, 2'b11, 1'b0);
      send(1'b1, 20'h00040, 16'h1234, 2'b01, 1'b0);
      ub_ok = 1'b1; lb_ok = 1'b1;
      for (int k = 1; k <= lat; k++) begin
         if (tr_ub[k] !== 1'b1) ub_ok = 1'b0;
         if (tr_lb[k] !== 1'b0) lb_ok = 1'b0;
      end
      total_cnt++;
      if (lat !== 4 || !ub_ok || !lb_ok || mem[8'h40] !== 16'hFF34)
         $display("[TB] FAIL lane_write: lat %0d ub_ok %b lb_ok %b mem %h want 4 1 1 ff34", lat, ub_ok, lb_ok, mem[8'h40]);
      else pass_cnt++;

      exp_q.push_back(16'hFF00);
      send(1'b0, 20'h00040, 16'h0000, 2'b10, 1'b0);
      total_cnt++;
      if (lat !== 4 || (lat > 0 && {tr_ub[1], tr_lb[1]} !== 2'b01))
         $display("[TB] FAIL lane_read_strobes: lat %0d ub/lb %b want 4 01", lat, {tr_ub[1], tr_lb[1]});
      else pass_cnt++;
      if (exp_q.size() > 0) begin
         total_cnt++;
         if (rdata !== exp_q[0])
            $display("[TB] FAIL lane_read_data: got %h want %h", rdata, exp_q[0]);
         else pass_cnt++;
         void'(exp_q.pop_front());
      end

      exp_q.push_back(16'h0000);
      send(1'b0, 20'h00040, 16'h0000, 2'b00, 1'b0);
      ub_ok = 1'b1;
      for (int k = 1; k <= lat; k++)
         if ({tr_ub[k], tr_lb[k]} !== 2'b11) ub_ok = 1'b0;
      total_cnt++;
      if (lat !== 4 || !ub_ok)
         $display("[TB] FAIL lane_none_strobes: lat %0d lanes_off %b want 4 1", lat, ub_ok);
      else pass_cnt++;
      if (exp_q.size() > 0) begin
         total_cnt++;
         if (rdata !== exp_q[0])
            $display("[TB] FAIL lane_none_data: got %h want %h", rdata, exp_q[0]);
         else pass_cnt++;
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_back_to_back();
      logic        b_rw   [0:2];
      logic [19:0] b_addr [0:2];
      logic [15:0] b_data [0:2];
      int acc [0:2];
      int idx, dcnt, rvcnt;
      b_rw[0] = 1'b1; b_addr[0] = 20'h00080; b_data[0] = 16'hA5A5;
      b_rw[1] = 1'b0; b_addr[1] = 20'h00080; b_data[1] = 16'h0000;
      b_rw[2] = 1'b1; b_addr[2] = 20'h00081; b_data[2] = 16'h0F0F;
      idx = 0; dcnt = 0; rvcnt = 0;
      acc[0] = -1; acc[1] = -1; acc[2] = -1;
      @(negedge clk);
      req = 1'b1; rw = b_rw[0]; addr = b_addr[0]; wdata = b_data[0]; be = 2'b11;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         if (done) dcnt++;
         if (rvalid) begin
            rvcnt++;
            if (exp_q.size() > 0) begin
               total_cnt++;
               if (rdata !== exp_q[0])
                  $display("[TB] FAIL b2b_rdata: got %h want %h", rdata, exp_q[0]);
               else pass_cnt++;
               void'(exp_q.pop_front());
            end
         end
         if (ready && req && idx < 3) begin
            if (!b_rw[idx]) exp_q.push_back(mem[b_addr[idx][7:0]]);
            acc[idx] = c;
            idx++;
            @(posedge clk);
            #1;
            if (idx < 3) begin
               rw = b_rw[idx]; addr = b_addr[idx]; wdata = b_data[idx];
            end else begin
               req = 1'b0;
            end
         end
         if (idx == 3 && dcnt == 3) break;
      end
      req = 1'b0;
      total_cnt++;
      if (acc[1] - acc[0] !== 5 || acc[2] - acc[1] !== 5)
         $display("[TB] FAIL b2b_spacing: got %0d %0d want 5 5", acc[1] - acc[0], acc[2] - acc[1]);
      else pass_cnt++;
      total_cnt++;
      if (dcnt !== 3 || rvcnt !== 1)
         $display("[TB] FAIL b2b_pulses: done %0d rvalid %0d want 3 1", dcnt, rvcnt);
      else pass_cnt++;
      total_cnt++;
      if (mem[8'h81] !== 16'h0F0F)
         $display("[TB] FAIL b2b_mem: got %h want 0f0f", mem[8'h81]);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_wait_cycles();
      int l0, l3;
      logic [15:0] d0, d3, expd;
      logic v0, v3;
      expd = 16'h0123 ^ 16'h5A5A;
      l0 = 0; l3 = 0; d0 = '0; d3 = '0; v0 = 0; v3 = 0;
      @(negedge clk);
      req0 = 1'b1; req3 = 1'b1; rw = 1'b0; addr = 20'h00123; be = 2'b11;
      @(posedge clk);
      #1;
      req0 = 1'b0; req3 = 1'b0; addr = 20'($urandom);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (done0 && l0 == 0) begin
            l0 = k; d0 = rdata0; v0 = rvalid0 & ~ub0 & ~lb0;
         end
         if (done3 && l3 == 0) begin
            l3 = k; d3 = rdata3; v3 = rvalid3 & ~ub3 & ~lb3;
         end
      end
      total_cnt++;
      if (l0 !== 3 || l3 !== 6)
         $display("[TB] FAIL wait_latency: got %0d %0d want 3 6", l0, l3);
      else pass_cnt++;
      total_cnt++;
      if (d0 !== expd || d3 !== expd || !v0 || !v3)
         $display("[TB] FAIL wait_data: got %h %h rvalid %b %b want %h", d0, d3, v0, v3, expd);
      else pass_cnt++;
   endtask

   task automatic test_ignored_inputs();
      logic addr_ok, rdy_ok, dq_ok;
      send(1'b1, 20'h00099, 16'h5555, 2'b11, 1'b1);
      addr_ok = 1'b1; rdy_ok = 1'b1; dq_ok = 1'b1;
      for (int k = 1; k <= lat; k++) begin
         if (tr_addr[k] !== 20'h00099) addr_ok = 1'b0;
         if (tr_rdy[k] !== 1'b0) rdy_ok = 1'b0;
         if (!tr_we[k] && tr_dq[k] !== 16'h5555) dq_ok = 1'b0;
      end
      total_cnt++;
      if (lat !== 4 || !addr_ok || !rdy_ok || !dq_ok)
         $display("[TB] FAIL ign_stable: lat %0d addr_ok %b ready_low %b dq_ok %b want 4 1 1 1", lat, addr_ok, rdy_ok, dq_ok);
      else pass_cnt++;
      total_cnt++;
      if (mem[8'h99] !== 16'h5555)
         $display("[TB] FAIL ign_mem: got %h want 5555", mem[8'h99]);
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      total_cnt++;
      if ({ready, ce_n} !== 2'b11)
         $display("[TB] FAIL ign_no_extra: ready/ce %b want 11", {ready, ce_n});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_access();
      int dseen;
      @(negedge clk);
      req = 1'b1; rw = 1'b1; addr = 20'h00055; wdata = 16'h7777; be = 2'b11;
      @(posedge clk);
      #1;
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total_cnt++;
      if ({ce_n, we_n} !== 2'b00)
         $display("[TB] FAIL rst_mid_pre: ce/we %b want 00", {ce_n, we_n});
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({ce_n, we_n, oe_n} !== 3'b111)
         $display("[TB] FAIL rst_mid_strobes: ce/we/oe %b want 111", {ce_n, we_n, oe_n});
      else pass_cnt++;
      dseen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done) dseen++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done) dseen++;
      end
      total_cnt++;
      if (dseen !== 0)
         $display("[TB] FAIL rst_mid_done: got %0d pulses want 0", dseen);
      else pass_cnt++;
      total_cnt++;
      if ({ready, ce_n} !== 2'b11 || s_addr !== 20'h0 || rdata !== 16'h0)
         $display("[TB] FAIL rst_mid_after: ready/ce %b addr %h rdata %h want 11 0 0", {ready, ce_n}, s_addr, rdata);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_back_to_back();
      test_wait_cycles();
      test_ignored_inputs();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
